// File: rtl/pipe_ctrl_if.sv
// Stall/flush handshake bundle between the pipeline stages and pipe_ctrl.
// master = pipeline side (drives requests), slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        br;
  logic [31:0] br_target;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br, br_target,
    input  stall, flush, redirect_valid, redirect_pc, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br, br_target,
    output stall, flush, redirect_valid, redirect_pc, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: deferred-branch replay and IF/ID refill window.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int REFILL_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_REFILL} state_e;

  localparam logic [3:0] REFILL_INIT  = 4'(REFILL_CYCLES);
  localparam state_e     REFILL_ENTRY = (REFILL_CYCLES == 0) ? ST_RUN : ST_REFILL;

  state_e      state, state_next;
  logic [3:0]  rc, rc_next;
  logic [31:0] pend_pc, pend_next;

  logic [4:0]  base_stall, base_flush;
  logic [4:0]  stall, flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deep, any_req;

  assign deep    = bus.stallreq_mem | bus.stallreq_ex;
  assign any_req = deep | bus.stallreq_id | bus.stallreq_if;

  // Deepest request wins: it holds its own stage and everything upstream.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    base_stall = 5'b00000;
    base_flush = 5'b00000;
    if (bus.stallreq_mem) begin
      base_stall = 5'b01111;
      base_flush = 5'b10000;
    end else if (bus.stallreq_ex) begin
      base_stall = 5'b00111;
      base_flush = 5'b01000;
    end else if (bus.stallreq_id) begin
      base_stall = 5'b00011;
      base_flush = 5'b00100;
    end else if (bus.stallreq_if) begin
      base_stall = 5'b00001;
      base_flush = 5'b00010;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      rc      <= 4'd0;
      pend_pc <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state   <= state_next;
      rc      <= rc_next;
      pend_pc <= pend_next;
    end
  end

  always_comb begin
    state_next = state;
    rc_next    = rc;
    pend_next  = pend_pc;
    unique case (state)
      ST_RUN, ST_REFILL: begin
        if (bus.br) begin
          if (deep) begin
            state_next = ST_PEND;
            pend_next  = bus.br_target;
          end else begin
            state_next = REFILL_ENTRY;
            rc_next    = REFILL_INIT;
          end
        end else if (state == ST_REFILL && !any_req) begin
          if (rc <= 4'd1) begin
            state_next = ST_RUN;
            rc_next    = 4'd0;
          end else begin
            rc_next = rc - 4'd1;
          end
        end
      end
      ST_PEND: begin
        // The branch is still held in EX, so a repeated br here is the same branch.
        if (!deep) begin
          state_next = REFILL_ENTRY;
          rc_next    = REFILL_INIT;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    stall          = base_stall;
    flush          = base_flush;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    unique case (state)
      ST_RUN, ST_REFILL: begin
        if (state == ST_REFILL && !base_stall[1]) flush[1] = 1'b1;
        if (bus.br && !deep) begin
          redirect_valid = 1'b1;
          redirect_pc    = bus.br_target;
          flush[2:1]     = 2'b11;
          stall[1:0]     = 2'b00;
        end
      end
      ST_PEND: begin
        if (!deep) begin
          redirect_valid = 1'b1;
          redirect_pc    = pend_pc;
          flush[2:1]     = 2'b11;
          stall[1:0]     = 2'b00;
        end
      end
      default: ;
    endcase
    // NOTE: outputs are gated by rst_n so they read zero immediately in reset, not only after state clears.
    if (!rst_n) begin
      stall          = 5'b00000;
      flush          = 5'b00000;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
    end
  end

  assign bus.stall          = stall;
  assign bus.flush          = flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall[0])       stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_flush_cnt = flush_cnt;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_flush_cnt = 32'd0;
`endif
endmodule
